pipe_stage: RTL
===============

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter: DATA_W, default 97, payload width in bits (pc 32 + alu 32 + rs2 32 + cmp 1).
REQ-002 Parameter: SKID, default 1, buffering mode: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-003 Parameter: ZERO_ON_FLUSH, default 1, data clearing on flush: 1 = flush clears stored data; 0 = flush leaves stored data unchanged.
REQ-004 Parameter: CNT_W, default 16, stall-counter width.
REQ-005 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous active-high reset.
REQ-007 Port: in_valid, input, 1, upstream offers in_data.
REQ-008 Port: in_ready, output, 1, stage can accept; a transfer occurs when in_valid && in_ready.
REQ-009 Port: in_data, input, DATA_W, upstream payload.
REQ-010 Port: flush, input, 1, synchronous squash of all held entries.
REQ-011 Port: out_valid, output, 1, out_data holds a live entry.
REQ-012 Port: out_ready, input, 1, downstream accepts; a transfer occurs when out_valid && out_ready.
REQ-013 Port: out_data, output, DATA_W, oldest held payload.
REQ-014 Port: occupancy, output, 2, number of held entries (0..2).
REQ-015 Port: clr_cnt, input, 1, synchronous clear of stall_cnt.
REQ-016 Port: stall_cnt, output, CNT_W, saturating count of cycles with out_valid && !out_ready.

Function
REQ-017 Storage: main register (drives out_data) and, when SKID=1, skid register; state EMPTY/ONE/FULL (FULL only when SKID=1).
REQ-018 Output flags: out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-019 SKID=1: in_ready = (state != FULL), decoded from state only, no combinational path from out_ready.
REQ-020 SKID=0: in_ready = !out_valid || out_ready (combinational).
REQ-021 EMPTY: accept -> ONE, main <= in_data; no accept -> stay.
REQ-022 ONE, accept and out fire -> ONE, main <= in_data.
REQ-023 ONE, accept only -> FULL (SKID=1), skid <= in_data; SKID=0 cannot reach this case.
REQ-024 ONE, out fire only -> EMPTY; neither -> hold.
REQ-025 FULL: out fire -> ONE, main <= skid; otherwise hold.
REQ-026 Ordering: entries leave in arrival order; no entry is lost or duplicated.
REQ-027 Latency: accepted data appears on out_data the cycle after acceptance when the stage was EMPTY or out fired that cycle.
REQ-028 Flush priority: flush overrides all transitions; next state EMPTY.
REQ-029 Flush side effects: any same-cycle input transfer is discarded.
REQ-030 Flush data: ZERO_ON_FLUSH=1 -> main and skid <= 0; ZERO_ON_FLUSH=0 -> data registers unchanged.
REQ-031 Flush counter: stall_cnt is unaffected by flush.
REQ-032 stall_cnt: +1 each cycle with out_valid && !out_ready; saturates at all-ones; never wraps.
REQ-033 clr_cnt: sets stall_cnt to 0, taking priority over increment in the same cycle.
REQ-034 Data stability: out_data shall not change while out_valid && !out_ready, except on flush.

Reset
REQ-035 Asynchronous reset: reset high immediately forces state EMPTY, main = 0, skid = 0, stall_cnt = 0.
REQ-036 Outputs under reset: out_valid = 0, occupancy = 0, in_ready = 1 (both modes); held for the duration of reset.
REQ-037 Reset mid-operation: asserting reset while FULL discards both entries; the first post-release accept behaves as from EMPTY.

Verification
REQ-038 Streaming (SKID=1): in_valid=1 and out_ready=1 continuously, data 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3 on consecutive cycles, one cycle after each accept; occupancy stays 1.
REQ-039 Backpressure (SKID=1): out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; then out_ready=1 -> 0xA, then 0xB, then out_valid=0.
REQ-040 Flush (SKID=1): FULL with 0xA/0xB, assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy=0, out_data=0 (ZERO_ON_FLUSH=1); 0xC never appears.
REQ-041 SKID=0 mode: out_ready=0 with one entry held -> in_ready=0; set out_ready=1 in the same cycle -> in_ready=1 and a new entry replaces the old one next cycle.
REQ-042 Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); pulse clr_cnt -> 0 next cycle.
REQ-043 Async reset: assert reset between clock edges while FULL -> out_valid=0, occupancy=0, stall_cnt=0 before the next rising edge.

Source files
------------

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//
// Purpose:
//   A valid/ready pipeline stage that carries one payload word per transfer.
//   It is built either as a two-entry skid buffer or as a single register.
//   The skid buffer registers in_ready, so there is no combinational path
//   from out_ready to in_ready. The single register accepts a new word in
//   the same cycle that its held word leaves, which makes its in_ready
//   combinational. A synchronous flush squashes every held entry. A
//   saturating counter records how many cycles the output was stalled.
//
// Parameters:
//   DATA_W        payload width in bits
//   SKID          1 = two-entry skid buffer, 0 = single register
//   ZERO_ON_FLUSH 1 = flush clears stored data, 0 = flush keeps stored data
//   CNT_W         stall counter width
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   upstream offers in_data
//   in_ready   stage can accept (transfer when in_valid && in_ready)
//   in_data    upstream payload
//   flush      synchronous squash of all held entries
//   out_valid  out_data holds a live entry
//   out_ready  downstream accepts (transfer when out_valid && out_ready)
//   out_data   oldest held payload
//   occupancy  number of held entries, 0..2
//   clr_cnt    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage #(
    parameter int DATA_W        = 97,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The encoding matches occupancy, so occupancy can be read from the
    // state register directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    // Skid mode decodes in_ready from state alone. Single-register mode may
    // accept while the held word drains, so it looks at out_ready.
    assign in_ready = (SKID != 0) ? (state_q != ST_FULL)
                                  : (!out_valid || out_ready);

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Next-state and data path. Flush wins over every transition, and it
    // discards any input transfer in the same cycle. The main register
    // always holds the oldest entry. The skid register holds only the
    // entry that arrived while the downstream was stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (ZERO_ON_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && out_fire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        // Single-register mode never accepts here without
                        // out_fire, so this case exists only with a skid
                        // register.
                        if (SKID != 0) begin
                            state_d = ST_FULL;
                            skid_d  = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Stall counter. Clear takes priority over increment. The counter holds
    // at all-ones instead of wrapping, and flush does not affect it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Every stored element returns to empty/zero as soon as reset is
    // asserted, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
